// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback select encodings, default data width and link-select helper.
package wb_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    function automatic logic is_link(input logic [1:0] sel);
        return sel >= WB_SEL_PC4;
    endfunction
endpackage

// File: rtl/wb_load_queue.sv
// wb_load_queue: circular FIFO of destination tags for outstanding loads.
// Ports: push/push_tag enqueue, pop dequeues head_tag, count/full/empty status,
// match_tag/match reports whether any valid entry holds match_tag,
// entry_valid/entry_tag expose every slot for the pending-register decode.
module wb_load_queue #(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [4:0]            push_tag,
    input  logic                  pop,
    output logic [4:0]            head_tag,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    input  logic [4:0]            match_tag,
    output logic                  match,
    output logic [DEPTH-1:0]      entry_valid,
    output logic [DEPTH-1:0][4:0] entry_tag
);
    logic [4:0]    tags [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full     = cnt == CW'(DEPTH);
    assign empty    = cnt == '0;
    assign count    = cnt;
    assign head_tag = tags[rd_ptr];
    assign do_pop   = pop && !empty;
    // a full queue can still accept a push when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
        end else begin
            if (do_push) begin
                tags[wr_ptr] <= push_tag;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // slot i is live when its distance from the head is below the occupancy
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        logic [PW-1:0] off;
        assign off            = PW'(i) - rd_ptr;
        assign entry_valid[i] = {1'b0, off} < cnt;
        assign entry_tag[i]   = tags[i];
    end

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) match = match | (entry_valid[i] && tags[i] == match_tag);
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: single register-file write-port arbiter; load returns beat ALU/link writes.
// Ports: ex_valid/ex_ready/ex_sel/ex_rd/ex_alu/ex_pc writeback request from execute,
// mem_rvalid/mem_rdata in-order load data, rf_we/rf_waddr/rf_wdata registered write,
// lq_count outstanding loads, err_unexpected sticky stray-response flag,
// rd_pending per-register pending-load bits (only when WB_SCOREBOARD_EN is defined).
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN     = wb_pkg::XLEN_DEFAULT,
    parameter int PC_W     = 10,
    parameter int LQ_DEPTH = 2,
    localparam int CW      = $clog2(LQ_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [1:0]      ex_sel,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_alu,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [CW-1:0]   lq_count,
    output logic            err_unexpected
`ifdef WB_SCOREBOARD_EN
    ,output logic [31:0]    rd_pending
`endif
);
    logic                    is_mem;
    logic                    pop;
    logic                    push;
    logic                    alu_fire;
    logic                    waw_hit;
    logic                    lq_full;
    logic                    lq_empty;
    logic                    tag_match;
    logic [4:0]              head_tag;
    logic [PC_W-1:0]         pc_inc;
    logic                    wr_en;
    logic [4:0]              wr_addr;
    logic [XLEN-1:0]         wr_data;
    logic [LQ_DEPTH-1:0]     entry_valid;
    logic [LQ_DEPTH-1:0][4:0] entry_tag;

    wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_tag    (ex_rd),
        .pop         (pop),
        .head_tag    (head_tag),
        .count       (lq_count),
        .full        (lq_full),
        .empty       (lq_empty),
        .match_tag   (ex_rd),
        .match       (tag_match),
        .entry_valid (entry_valid),
        .entry_tag   (entry_tag)
    );

    assign is_mem   = ex_sel == WB_SEL_MEM;
    assign pop      = mem_rvalid && !lq_empty;
    assign waw_hit  = ex_rd != '0 && tag_match;
    assign ex_ready = is_mem ? (!lq_full || pop) : (!pop && !waw_hit);
    assign push     = ex_valid && ex_ready && is_mem;
    assign alu_fire = ex_valid && ex_ready && !is_mem;
    assign pc_inc   = ex_pc + PC_W'(1);

    // x0 destinations never reach the port; loads to x0 still pop to keep responses aligned
    always_comb begin
        wr_addr = pop ? head_tag : ex_rd;
        wr_data = pop ? mem_rdata : (is_link(ex_sel) ? XLEN'(pc_inc) : ex_alu);
        wr_en   = (pop || alu_fire) && wr_addr != '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            rf_we <= wr_en;
            if (wr_en) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
            end
            if (mem_rvalid && lq_empty) err_unexpected <= 1'b1;
        end
    end

`ifdef WB_SCOREBOARD_EN
    always_comb begin
        rd_pending = '0;
        for (int i = 0; i < LQ_DEPTH; i++) if (entry_valid[i]) rd_pending[entry_tag[i]] = 1'b1;
        rd_pending[0] = 1'b0;
    end
`else
    logic unused_view;
    assign unused_view = ^{entry_valid, entry_tag};
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench with a queue-based reference model.
module tb_wb_arbiter;
    localparam int XLEN = 32;
    localparam int PC_W = 10;
    localparam int LQ_DEPTH = 2;
    localparam int CW = $clog2(LQ_DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_ready;
    logic [1:0]      ex_sel = '0;
    logic [4:0]      ex_rd = '0;
    logic [XLEN-1:0] ex_alu = '0;
    logic [PC_W-1:0] ex_pc = '0;
    logic            mem_rvalid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [CW-1:0]   lq_count;
    logic            err_unexpected;
`ifdef WB_SCOREBOARD_EN
    logic [31:0]     rd_pending;
`endif

    int tests = 0;
    int fails = 0;

    wb_arbiter #(.XLEN(XLEN), .PC_W(PC_W), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_sel         (ex_sel),
        .ex_rd          (ex_rd),
        .ex_alu         (ex_alu),
        .ex_pc          (ex_pc),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .lq_count       (lq_count),
        .err_unexpected (err_unexpected)
`ifdef WB_SCOREBOARD_EN
        ,.rd_pending    (rd_pending)
`endif
    );

    always #5 clk = ~clk;

    // reference model: outstanding tags as a plain queue, expected port values
    int        mq[$];
    logic      m_we = 1'b0;
    int        m_waddr = 0;
    logic [31:0] m_wdata = '0;
    logic      m_err = 1'b0;

    function automatic logic m_ready();
        logic hit = 1'b0;
        logic resp = mem_rvalid && mq.size() != 0;
        foreach (mq[k]) if (ex_rd != 0 && mq[k] == int'(ex_rd)) hit = 1'b1;
        if (ex_sel == 2'd1) return mq.size() < LQ_DEPTH || resp;
        return !resp && !hit;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (mq[k]) if (mq[k] != 0) p[mq[k]] = 1'b1;
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_we = 1'b0;
            m_waddr = 0;
            m_wdata = '0;
            m_err = 1'b0;
        end else begin
            logic rdy;
            int t;
            rdy = m_ready();
            m_we = 1'b0;
            if (mem_rvalid && mq.size() == 0) m_err = 1'b1;
            if (mem_rvalid && mq.size() != 0) begin
                t = mq.pop_front();
                if (t != 0) begin
                    m_we = 1'b1;
                    m_waddr = t;
                    m_wdata = mem_rdata;
                end
            end else if (ex_valid && rdy && ex_sel != 2'd1 && ex_rd != 0) begin
                m_we = 1'b1;
                m_waddr = ex_rd;
                m_wdata = ex_sel >= 2'd2 ? 32'((int'(ex_pc) + 1) % (1 << PC_W)) : ex_alu;
            end
            if (ex_valid && rdy && ex_sel == 2'd1) mq.push_back(int'(ex_rd));
        end
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) chk("ex_ready", 64'(ex_ready), 64'(m_ready()));
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        chk("lq_count", 64'(lq_count), 64'(mq.size()));
        chk("err_unexpected", 64'(err_unexpected), 64'(m_err));
`ifdef WB_SCOREBOARD_EN
        chk("rd_pending", 64'(rd_pending), 64'(m_pending()));
`endif
    end

    task automatic cyc(input logic v, input logic [1:0] s, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [9:0] pc,
                       input logic rv, input logic [31:0] rdat, output logic rdy);
        ex_valid = v;
        ex_sel = s;
        ex_rd = rd;
        ex_alu = alu;
        ex_pc = pc;
        mem_rvalid = rv;
        mem_rdata = rdat;
        #1 rdy = ex_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic r;
        repeat (3) @(posedge clk);
        #1 chk("reset_we", 64'(rf_we), 0);
        chk("reset_waddr", 64'(rf_waddr), 0);
        chk("reset_wdata", 64'(rf_wdata), 0);
        chk("reset_count", 64'(lq_count), 0);
        rst_n = 1'b1;
        cyc(1, 2'd0, 5, 32'hDEADBEEF, 0, 0, 0, r);
        chk("alu_we", 64'(rf_we), 1);
        chk("alu_waddr", 64'(rf_waddr), 5);
        chk("alu_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        cyc(0, 2'd0, 0, 0, 0, 0, 0, r);
        chk("idle_we", 64'(rf_we), 0);
        chk("idle_hold", 64'(rf_wdata), 64'hDEADBEEF);
        cyc(1, 2'd2, 1, 0, 10'h3FF, 0, 0, r);
        chk("link_wrap", 64'(rf_wdata), 0);
        chk("link_we", 64'(rf_we), 1);
        cyc(1, 2'd3, 2, 0, 10'd7, 0, 0, r);
        chk("link_7", 64'(rf_wdata), 8);
        cyc(1, 2'd1, 3, 0, 0, 0, 0, r);
        chk("load_count", 64'(lq_count), 1);
        chk("load_nowrite", 64'(rf_we), 0);
        cyc(1, 2'd0, 4, 32'h44, 0, 1, 32'h55, r);
        chk("conflict_ready", 64'(r), 0);
        chk("pop_waddr", 64'(rf_waddr), 3);
        chk("pop_wdata", 64'(rf_wdata), 64'h55);
        cyc(1, 2'd0, 4, 32'h44, 0, 0, 0, r);
        chk("retry_ready", 64'(r), 1);
        chk("retry_waddr", 64'(rf_waddr), 4);
        chk("retry_wdata", 64'(rf_wdata), 64'h44);
        cyc(1, 2'd1, 7, 0, 0, 0, 0, r);
        cyc(1, 2'd0, 7, 32'h70, 0, 0, 0, r);
        chk("waw_ready", 64'(r), 0);
        chk("waw_nowrite", 64'(rf_we), 0);
        cyc(1, 2'd0, 7, 32'h70, 0, 1, 32'h77, r);
        chk("waw_pop_ready", 64'(r), 0);
        chk("waw_pop_wdata", 64'(rf_wdata), 64'h77);
        cyc(1, 2'd0, 7, 32'h70, 0, 0, 0, r);
        chk("waw_clear_ready", 64'(r), 1);
        chk("waw_clear_wdata", 64'(rf_wdata), 64'h70);
        cyc(1, 2'd0, 0, 32'h12, 0, 0, 0, r);
        chk("x0_we", 64'(rf_we), 0);
        chk("x0_hold", 64'(rf_wdata), 64'h70);
        cyc(1, 2'd1, 8, 0, 0, 0, 0, r);
        cyc(1, 2'd1, 9, 0, 0, 0, 0, r);
        chk("full_count", 64'(lq_count), 2);
        cyc(1, 2'd1, 10, 0, 0, 0, 0, r);
        chk("full_stall", 64'(r), 0);
        chk("full_stall_count", 64'(lq_count), 2);
        cyc(1, 2'd1, 10, 0, 0, 1, 32'h88, r);
        chk("full_pushpop_ready", 64'(r), 1);
        chk("full_pushpop_count", 64'(lq_count), 2);
        chk("full_pop_waddr", 64'(rf_waddr), 8);
        cyc(0, 2'd0, 0, 0, 0, 1, 32'h99, r);
        chk("drain9", 64'(rf_waddr), 9);
        cyc(0, 2'd0, 0, 0, 0, 1, 32'hAA, r);
        chk("drain10_addr", 64'(rf_waddr), 10);
        chk("drain10_data", 64'(rf_wdata), 64'hAA);
        chk("drain_count", 64'(lq_count), 0);
        cyc(0, 2'd0, 0, 0, 0, 1, 32'hBB, r);
        chk("err_set", 64'(err_unexpected), 1);
        chk("err_nowrite", 64'(rf_we), 0);
        chk("err_drop", 64'(rf_wdata), 64'hAA);
        cyc(0, 2'd0, 0, 0, 0, 0, 0, r);
        chk("err_sticky", 64'(err_unexpected), 1);
        cyc(1, 2'd1, 11, 0, 0, 0, 0, r);
        cyc(1, 2'd1, 12, 0, 0, 0, 0, r);
        chk("pre_reset_count", 64'(lq_count), 2);
        ex_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk("rst_count", 64'(lq_count), 0);
        chk("rst_err", 64'(err_unexpected), 0);
        chk("rst_waddr", 64'(rf_waddr), 0);
        chk("rst_wdata", 64'(rf_wdata), 0);
`ifdef WB_SCOREBOARD_EN
        chk("rst_pending", 64'(rd_pending), 0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 2'd0, 0, 0, 0, 1, 32'hCC, r);
        chk("late_resp_err", 64'(err_unexpected), 1);
        chk("late_resp_nowrite", 64'(rf_we), 0);
        cyc(0, 2'd0, 0, 0, 0, 0, 0, r);
        cyc(0, 2'd0, 0, 0, 0, 0, 0, r);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and sequencer for the single register-file write port. Accepts writeback requests from execute using the same select encoding as the mem-to-reg mux (ALU, memory load, PC+1 link). Tracks outstanding loads in a small tag queue until their data returns from data memory. Grants one register write per cycle and stalls execute on port conflicts and write-after-write hazards.

## Interface
- XLEN, 32, data width
- PC_W, 10, word-indexed PC width
- LQ_DEPTH, 2, outstanding-load queue depth; power of two, ≥2
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute presents a writeback request
- ex_ready  out  1  request accepted this cycle when ex_valid && ex_ready
- ex_sel  in  2  0 = ALU result, 1 = memory load, 2/3 = PC+1 link
- ex_rd  in  5  destination register
- ex_alu  in  XLEN  ALU result
- ex_pc  in  PC_W  current PC (word index)
- mem_rvalid  in  1  load data valid from data memory (in issue order, no backpressure)
- mem_rdata  in  XLEN  load data
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- lq_count  out  $clog2(LQ_DEPTH)+1  outstanding loads
- err_unexpected  out  1  sticky; mem_rvalid seen with empty queue
- rd_pending  out  32  per-register pending-load bits (only with WB_SCOREBOARD_EN)

## Operation
- At most one register write per cycle. Priority: load return (queue pop) > ALU/link request.
- ex_sel=1: no write; pushes ex_rd into load queue. ex_ready = !lq_full || (mem_rvalid && lq_count≠0).
- ex_sel=0/2/3: ex_ready = !(mem_rvalid && lq_count≠0) && !waw_hit. waw_hit = ex_rd≠0 and ex_rd matches any valid queue entry.
- ex_ready is combinational from ex_sel, ex_rd, mem_rvalid and queue state. It is not a function of ex_valid.
- Link data = zero-extend(ex_pc + 1) to XLEN; the add is done at PC_W and wraps at 2^PC_W.
- Pop (mem_rvalid && lq_count≠0): write mem_rdata to the head tag.
- mem_rvalid with lq_count=0: no write, data dropped, err_unexpected set until reset.
- Writes to x0 are suppressed (rf_we stays 0). Loads to x0 are still queued so response counting stays aligned.
- Push and pop in the same cycle are legal in every state, including full; lq_count is unchanged.
- Queue pointers wrap modulo LQ_DEPTH.

## Timing
- Accepted ALU/link request or pop in cycle N → rf_we/rf_waddr/rf_wdata valid in cycle N+1, held one cycle.
- Cycles with no write: rf_we=0; rf_waddr and rf_wdata hold their last values.
- Load issue to earliest write: 2 cycles (push at N, mem_rvalid at N+1, write visible at N+2).
- Reset (async assert, sync release): rf_we=0, rf_waddr=0, rf_wdata=0, queue empty, lq_count=0, err_unexpected=0, rd_pending=0.
- Reset mid-operation discards outstanding tags. A response arriving after reset sets err_unexpected.

## Configuration
- WB_SCOREBOARD_EN defined: rd_pending port present. rd_pending[r] = OR over valid entries of (tag==r), for r≠0, decoded combinationally from queue contents. Execute uses it for RAW stalls on pending loads.
- Undefined: rd_pending port and decode logic absent. The WAW check in ex_ready is present in both builds.

## Structure
- Package wb_pkg: XLEN default, WB_SEL_ALU=2'd0, WB_SEL_MEM=2'd1, WB_SEL_PC4=2'd2, function is_link(sel) (sel[1]).
- Sub-module wb_load_queue: circular tag FIFO with push/pop/count, full/empty, a single-tag match output, and a per-entry valid/tag view for the scoreboard decode.

## Test plan
- ALU write: ex_sel=0, rd=5, alu=0xDEADBEEF → next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF.
- Link: ex_sel=2, ex_pc=10'h3FF → rf_wdata=0 (wrap). ex_sel=3, ex_pc=7 → rf_wdata=8.
- Load then conflict: load rd=3, next cycle mem_rvalid=1 with data 0x55 while ALU rd=4 is valid → ex_ready=0, rd 3 written with 0x55; ALU rd=4 written one cycle later.
- WAW: load rd=7 pending, ALU rd=7 → ex_ready=0 until the load writes; x0 ALU write → rf_we=0.
- Full queue (depth 2): third load stalls; the same third load with mem_rvalid in the same cycle → accepted, lq_count stays 2.
- Errors/reset: mem_rvalid with empty queue → err_unexpected=1 and sticky, no write. rst_n low with 2 loads pending → lq_count=0, rd_pending=0, all outputs zero.
